// File: rtl/key_schedule_controller.sv
// key_schedule_controller: sequences a key-expansion engine, banks its ten round keys
// and streams them out over a valid/ready port in forward or decrypt order.
module key_schedule_controller #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit REVERSE = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_load,
  input  logic [255:0]   key_in,
  output logic           ks_enable,
  output logic [255:0]   ks_key,
  input  logic           ks_finish,
  input  logic [1279:0]  ks_keys,
  input  logic           stream_start,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [127:0]   rk_data,
  output logic [3:0]     rk_idx,
  output logic           rk_last,
  output logic           keys_valid,
  output logic           busy,
  output logic           err
);
  typedef enum logic [2:0] {IDLE, START, WAIT, CAPTURE, RELEASE, READY, STREAM, DRAIN} state_t;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] FIRST = REVERSE ? 4'd10 : 4'd1;
  localparam logic [3:0] LAST = REVERSE ? 4'd1 : 4'd10;
  state_t          state_q, state_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [255:0]    ks_key_q, ks_key_d;
  logic [1279:0]   bank_q, bank_d;
  logic            ks_enable_q, ks_enable_d;
  logic            keys_valid_q, keys_valid_d;
  logic            rk_valid_q, rk_valid_d;
  logic [3:0]      rk_idx_q, rk_idx_d;
  logic [127:0]    rk_data_q, rk_data_d;
  logic            rk_last_q, rk_last_d;
  logic            err_q, err_d;
  logic            load_ok, step;
  logic [3:0]      nidx;
  always_comb begin
    state_d = state_q;
    wd_d = wd_q;
    ks_key_d = ks_key_q;
    bank_d = bank_q;
    rk_valid_d = rk_valid_q;
    step = 1'b0;
    nidx = FIRST;
    load_ok = key_load && (state_q == IDLE || state_q == READY);
    err_d = (key_load && !load_ok) || (stream_start && (state_q != READY || key_load));
    if (load_ok) begin
      state_d = START;
      ks_key_d = key_in;
    end else begin
      case (state_q)
        START: begin
          wd_d = '0;
          state_d = WAIT;
        end
        WAIT:
          if (ks_finish) state_d = CAPTURE;
          else if (wd_q == WD_LAST) begin
            state_d = DRAIN;
            err_d = 1'b1;
          end else wd_d = wd_q + 1'b1;
        CAPTURE: begin
          bank_d = ks_keys;
          state_d = RELEASE;
        end
        RELEASE: state_d = ks_finish ? RELEASE : READY;
        READY:
          if (stream_start) begin
            state_d = STREAM;
            rk_valid_d = 1'b1;
            step = 1'b1;
          end
        STREAM:
          if (rk_valid_q && rk_ready) begin
            if (rk_last_q) begin
              state_d = READY;
              rk_valid_d = 1'b0;
            end else begin
              step = 1'b1;
              nidx = REVERSE ? rk_idx_q - 4'd1 : rk_idx_q + 4'd1;
            end
          end
        DRAIN: state_d = ks_finish ? DRAIN : IDLE;
        default: state_d = state_q;
      endcase
    end
    // Registered outputs follow the next state so they line up with it.
    ks_enable_d = state_d == START || state_d == WAIT;
    keys_valid_d = state_d == READY || state_d == STREAM;
    rk_idx_d = step ? nidx : rk_idx_q;
    rk_data_d = step ? bank_q[{nidx - 4'd1, 7'd0} +: 128] : rk_data_q;
    rk_last_d = step ? nidx == LAST : rk_last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wd_q <= '0;
      ks_key_q <= '0;
      bank_q <= '0;
      ks_enable_q <= 1'b0;
      keys_valid_q <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_idx_q <= '0;
      rk_data_q <= '0;
      rk_last_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q <= wd_d;
      ks_key_q <= ks_key_d;
      bank_q <= bank_d;
      ks_enable_q <= ks_enable_d;
      keys_valid_q <= keys_valid_d;
      rk_valid_q <= rk_valid_d;
      rk_idx_q <= rk_idx_d;
      rk_data_q <= rk_data_d;
      rk_last_q <= rk_last_d;
      err_q <= err_d;
    end
  end
  assign ks_enable = ks_enable_q;
  assign ks_key = ks_key_q;
  assign keys_valid = keys_valid_q;
  assign rk_valid = rk_valid_q;
  assign rk_idx = rk_idx_q;
  assign rk_data = rk_data_q;
  assign rk_last = rk_last_q;
  assign err = err_q;
  assign busy = state_q != IDLE && state_q != READY;
endmodule

// File: tb/tb_key_schedule_controller.sv
// tb_key_schedule_controller: directed checks of the key schedule controller against
// a behavioural engine that raises finish 40 cycles after enable and returns a fixed key table.
module tb_key_schedule_controller;
  localparam logic [255:0] KEY = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
  localparam logic [255:0] KEY2 = 256'h0f1e2d3c4b5a69788796a5b4c3d2e1f00112233445566778899aabbccddeeff;
  logic clk, rst_n, key_load, ks_enable, ks_finish, stream_start;
  logic rk_valid, rk_ready, rk_last, keys_valid, busy, err;
  logic [255:0] key_in, ks_key;
  logic [1279:0] ks_keys;
  logic [127:0] rk_data;
  logic [3:0] rk_idx;
  logic [127:0] kv [1:10];
  logic eng_dead;
  int ecnt, total, bad, rv, n, e, k;
  key_schedule_controller dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
    .ks_enable(ks_enable), .ks_key(ks_key), .ks_finish(ks_finish), .ks_keys(ks_keys),
    .stream_start(stream_start), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_idx(rk_idx), .rk_last(rk_last),
    .keys_valid(keys_valid), .busy(busy), .err(err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    kv[1] = KEY[255:128];
    kv[2] = KEY[127:0];
    for (int i = 3; i <= 9; i++) kv[i] = {32{4'(i)}};
    kv[10] = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
  end
  always_comb begin
    ks_keys = '0;
    for (int i = 1; i <= 10; i++) ks_keys[(i-1)*128 +: 128] = kv[i];
  end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ecnt <= 0;
      ks_finish <= 1'b0;
    end else if (!ks_enable) begin
      ecnt <= 0;
      ks_finish <= 1'b0;
    end else if (!eng_dead) begin
      if (ecnt == 39) ks_finish <= 1'b1;
      else ecnt <= ecnt + 1;
    end
  task automatic chk(input string tag, input logic [399:0] o, input logic [399:0] x);
    total++;
    assert (o === x) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, o, x);
    end
  endtask
  task automatic cyc(input int c);
    repeat (c) @(negedge clk);
  endtask
  task automatic wait_kv(output int rvc);
    rvc = 0;
    for (int i = 0; i < 200; i++) begin
      if (keys_valid) break;
      if (rk_valid) rvc++;
      @(negedge clk);
    end
  endtask
  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; key_load = 1'b0; key_in = '0; stream_start = 1'b0; rk_ready = 1'b0; eng_dead = 1'b0;
    @(negedge clk);
    chk("reset_outs", {ks_enable, ks_key, rk_valid, rk_data, rk_idx, rk_last, keys_valid, busy, err}, '0);
    rst_n = 1'b1;
    stream_start = 1'b1;
    @(negedge clk);
    stream_start = 1'b0;
    chk("idle_stream_err", err, 1);
    chk("idle_stream_busy", busy, 0);
    @(negedge clk);
    chk("err_one_cycle", err, 0);
    key_in = KEY; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0; key_in = '0;
    chk("load_enable", ks_enable, 1);
    chk("load_key", ks_key, KEY);
    chk("load_kv", keys_valid, 0);
    chk("load_busy", busy, 1);
    cyc(3);
    key_in = KEY2; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    chk("wait_load_err", err, 1);
    chk("wait_load_key", ks_key, KEY);
    chk("wait_load_en", ks_enable, 1);
    wait_kv(rv);
    chk("exp_kv", keys_valid, 1);
    chk("exp_finish_low", ks_finish, 0);
    chk("exp_en_low", ks_enable, 0);
    chk("exp_busy", busy, 0);
    stream_start = 1'b1; rk_ready = 1'b1;
    @(negedge clk);
    stream_start = 1'b0;
    for (int i = 10; i >= 1; i--) begin
      chk("beat_valid", rk_valid, 1);
      chk("beat_idx", rk_idx, i);
      chk("beat_data", rk_data, kv[i]);
      chk("beat_last", rk_last, i == 1);
      key_load = i == 10;
      @(negedge clk);
      key_load = 1'b0;
      if (i == 10) chk("stream_load_err", err, 1);
    end
    chk("stream_end_valid", rk_valid, 0);
    chk("stream_end_kv", keys_valid, 1);
    chk("stream_end_busy", busy, 0);
    chk("stream_key_kept", ks_key, KEY);
    e = 10; k = 0;
    stream_start = 1'b1; rk_ready = 1'b0;
    @(negedge clk);
    stream_start = 1'b0;
    while (e > 0 && k < 40) begin
      chk("stall_valid", rk_valid, 1);
      chk("stall_idx", rk_idx, e);
      chk("stall_data", rk_data, kv[e]);
      chk("stall_last", rk_last, e == 1);
      rk_ready = k[0];
      @(negedge clk);
      if (rk_ready) e--;
      k++;
    end
    rk_ready = 1'b0;
    chk("stall_cycles", k, 20);
    chk("stall_end_valid", rk_valid, 0);
    chk("stall_end_kv", keys_valid, 1);
    key_in = KEY2; key_load = 1'b1; stream_start = 1'b1;
    @(negedge clk);
    key_load = 1'b0; stream_start = 1'b0;
    chk("both_err", err, 1);
    chk("both_en", ks_enable, 1);
    chk("both_key", ks_key, KEY2);
    chk("both_no_valid", rk_valid, 0);
    chk("both_kv", keys_valid, 0);
    @(negedge clk);
    chk("both_err_once", err, 0);
    wait_kv(rv);
    chk("both_done_kv", keys_valid, 1);
    chk("both_rv_never", rv, 0);
    eng_dead = 1'b1;
    key_in = KEY; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0; n = 0;
    for (int i = 1; i <= 400; i++) begin
      if (err) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
    chk("timeout_cycle", n, 257);
    chk("timeout_en", ks_enable, 0);
    chk("timeout_kv", keys_valid, 0);
    chk("timeout_drain_busy", busy, 1);
    @(negedge clk);
    chk("timeout_err_once", err, 0);
    chk("timeout_idle", busy, 0);
    eng_dead = 1'b0;
    key_in = KEY; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    cyc(5);
    chk("pre_rst_en", ks_enable, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_outs", {ks_enable, ks_key, rk_valid, rk_data, rk_idx, rk_last, keys_valid, busy, err}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    key_in = KEY2; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    chk("post_rst_en", ks_enable, 1);
    chk("post_rst_key", ks_key, KEY2);
    wait_kv(rv);
    chk("post_rst_kv", keys_valid, 1);
    stream_start = 1'b1;
    @(negedge clk);
    stream_start = 1'b0;
    chk("post_rst_idx", rk_idx, 10);
    chk("post_rst_data", rk_data, kv[10]);
    rk_ready = 1'b1;
    cyc(10);
    chk("post_rst_end", rk_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
